// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with bounded lock that shares one
// single-port read-first memory between a loader port and a compute port.
module mem_arbiter #(
    parameter int WIDTH    = 16,
    parameter int SIZE     = 64,
    parameter int LOCK_MAX = 16,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid0,
    input  logic               req_valid1,
    output logic               req_ready0,
    output logic               req_ready1,
    input  logic               req_wr0,
    input  logic               req_wr1,
    input  logic               req_lock0,
    input  logic               req_lock1,
    input  logic [LOGSIZE-1:0] req_addr0,
    input  logic [LOGSIZE-1:0] req_addr1,
    input  logic [WIDTH-1:0]   req_wdata0,
    input  logic [WIDTH-1:0]   req_wdata1,
    output logic               rsp_valid0,
    output logic               rsp_valid1,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               lock_timeout,
    output logic [LOGSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]   mem_data_in,
    output logic               mem_wr_en,
    input  logic [WIDTH-1:0]   mem_data_out
);

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    generate
        if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_size_check
            $error("mem_arbiter: SIZE must be a power of two");
        end
    endgenerate

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;
    logic             to_q, to_d;
    logic             rsp0_q, rsp0_d;
    logic             rsp1_q, rsp1_d;

    logic gnt0, gnt1;
    logic xfer, win_wr, win_lock, timeout;

    // Locked owner excludes the other port even when the owner is idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (state_q == LOCKED) begin
                gnt0 = !owner_q && req_valid0;
                gnt1 = owner_q && req_valid1;
            end else if (req_valid0 && req_valid1) begin
                gnt0 = rr_q;
                gnt1 = !rr_q;
            end else begin
                gnt0 = req_valid0;
                gnt1 = req_valid1;
            end
        end
    end

    assign xfer     = gnt0 | gnt1;
    assign win_wr   = gnt1 ? req_wr1 : req_wr0;
    assign win_lock = gnt1 ? req_lock1 : req_lock0;

    assign timeout = (state_q == LOCKED) && (LOCK_MAX != 0) &&
                     (cnt_q == CNT_W'(LOCK_MAX - 1));

    assign mem_addr    = gnt1 ? req_addr1  : (gnt0 ? req_addr0  : '0);
    assign mem_data_in = gnt1 ? req_wdata1 : (gnt0 ? req_wdata0 : '0);
    assign mem_wr_en   = xfer && win_wr;

    assign req_ready0   = gnt0;
    assign req_ready1   = gnt1;
    assign rsp_valid0   = rsp0_q;
    assign rsp_valid1   = rsp1_q;
    assign rsp_data     = mem_data_out;
    assign lock_timeout = to_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = xfer ? gnt1 : rr_q;
        to_d    = 1'b0;
        rsp0_d  = gnt0 && !req_wr0;
        rsp1_d  = gnt1 && !req_wr1;
        unique case (state_q)
            UNLOCKED: begin
                if (xfer && win_lock) begin
                    state_d = LOCKED;
                    owner_d = gnt1;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                // Forced release wins over the lock bit of a same-cycle transfer.
                if (timeout) begin
                    state_d = UNLOCKED;
                    rr_d    = owner_q;
                    to_d    = 1'b1;
                end else if (xfer && !win_lock) begin
                    state_d = UNLOCKED;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UNLOCKED;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            rr_q    <= 1'b1;
            to_q    <= 1'b0;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            to_q    <= to_d;
            rsp0_q  <= rsp0_d;
            rsp1_q  <= rsp1_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one single-port, read-first memory instance (WIDTH x SIZE, 1-cycle registered read) between port 0 (loader/host) and port 1 (compute datapath).
- Applies round-robin arbitration with an optional bounded lock, so a requester can run an uninterrupted burst.
- Drives the memory's addr/data_in/wr_en directly and routes each 1-cycle-late read response back to the port that issued the read.

Parameters:
- WIDTH, 16, data width; must match the memory.
- SIZE, 64, memory depth in words; address width LOGSIZE = $clog2(SIZE) (localparam).
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held; 0 = no limit.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid0 / req_valid1  input  1  port p has a request.
- req_ready0 / req_ready1  output  1  request of port p accepted this cycle.
- req_wr0 / req_wr1  input  1  1 = write, 0 = read.
- req_lock0 / req_lock1  input  1  request or keep exclusive ownership after this transfer.
- req_addr0 / req_addr1  input  LOGSIZE  word address.
- req_wdata0 / req_wdata1  input  WIDTH  write data.
- rsp_valid0 / rsp_valid1  output  1  read data for port p is valid this cycle.
- rsp_data  output  WIDTH  shared read-data bus, equal to mem_data_out.
- lock_timeout  output  1  one-cycle pulse when a lock is forcibly released.
- mem_addr  output  LOGSIZE  to memory addr.
- mem_data_in  output  WIDTH  to memory data_in.
- mem_wr_en  output  1  to memory wr_en.
- mem_data_out  input  WIDTH  from memory data_out.

Behaviour:
- **Handshake.** A transfer occurs on a cycle where req_valid_p && req_ready_p.
  - Requesters hold addr/wdata/wr/lock stable until accepted.
  - At most one ready is high per cycle.
  - req_ready_p never depends on the requester's own ready (no loops).
- **Grant (combinational from state + valids).**
  - If locked: only the lock owner may be granted; the other port's ready is 0 even if the owner's valid is low.
  - Else, only one valid: that port wins.
  - Else, both valid: the port != rr_last wins.
  - Else, no grant.
- **Memory drive.**
  - mem_addr/mem_data_in follow the granted port; they are 0 when there is no grant.
  - mem_wr_en = grant && req_wr of the winner.
  - While reset is high: all readies = 0 and mem_wr_en = 0.
- **rr_last register.** Updated to the granted port on every transfer. Reset value = 1, so port 0 wins the first tie.
- **Read response.**
  - A read accepted in cycle N gives rsp_valid_p = 1 in cycle N+1, with rsp_data = mem_data_out (the memory's registered read of addr in cycle N).
  - Back-to-back reads from alternating ports each return exactly one cycle later, in issue order.
  - Writes produce no response.
  - A write and a read of the same address on consecutive cycles: the read returns the new data. A read-write to the same address in the same cycle is impossible (single grant).
- **No response backpressure.** Consumers must accept rsp_valid when it is asserted.
- **Lock state machine, states UNLOCKED / LOCKED(owner).**
  - UNLOCKED -> LOCKED(p): on a transfer from p with req_lock_p = 1.
  - LOCKED(p) -> UNLOCKED: on a transfer from p with req_lock_p = 0.
  - LOCKED(p) -> UNLOCKED (timeout): when LOCK_MAX != 0 and lock_cnt == LOCK_MAX-1 at the edge. lock_timeout pulses for 1 cycle, in the first UNLOCKED cycle.
  - lock_cnt: cleared on entering LOCKED, +1 every LOCKED cycle, saturating.
  - A transfer on the timeout cycle is still accepted. Its lock bit is ignored, so the lock cannot be re-acquired that cycle.
  - After a timeout, rr_last = owner, so the other port wins the next tie.
- **Reset values (asynchronous assertion).**
  - rsp_valid0/1 = 0, lock_timeout = 0, state = UNLOCKED, lock_cnt = 0, rr_last = 1.
  - A pending read response is dropped.
  - After deassertion, the first edge behaves as from a clean state.
- **Sizing.** Addresses are used modulo SIZE. SIZE must be a power of two; this is enforced by an elaboration check.

Test Plan:
- **Basic write/read.** Port 0 writes 0x1234 to addr 5, then reads addr 5. Required: ready0 = 1 on each request; rsp_valid0 = 1 one cycle after the read, with rsp_data = 0x1234; rsp_valid1 stays 0.
- **Round-robin tie.** Both ports hold reads of addr 1 / addr 2 (preloaded 0xAAAA / 0xBBBB) continuously. Required: grants go 0, 1, 0, 1…; responses alternate rsp_valid0 = 0xAAAA and rsp_valid1 = 0xBBBB, each one cycle after its grant.
- **Lock burst.** Port 1 issues 4 writes (lock = 1, 1, 1, 0) to addrs 10–13 while port 0 requests continuously. Required: port 0 gets ready0 = 0 through all 4 transfers, is granted on the next cycle, and sees no lock_timeout.
- **Lock timeout.** LOCK_MAX = 4; port 0 locks, then drops valid while holding the lock, and port 1 requests. Required: ready1 = 0 for 4 cycles, lock_timeout pulses once, then ready1 = 1.
- **Reset mid-operation.** Assert reset the cycle after a port 1 read is accepted. Required: rsp_valid1 never rises; mem_wr_en = 0 and readies = 0 during reset. After release, with both ports valid, port 0 is granted first.
- **Write-then-read.** Port 0 writes 0x00FF to addr 63; port 1 reads addr 63 on the next cycle. Required: rsp_data = 0x00FF with rsp_valid1 = 1.
